// File: rtl/multicycle_ctrl_v2.sv
// Multi-cycle control FSM for the 16-bit core: sequences fetch/decode/exec/mem/wb.
// Ports: CLK, Reset (sync, active-low), opcode, funct, mem_ready, stall in;
//        datapath controls, state, trap, trap_cause, retired out.
module multicycle_ctrl_v2 #(
    parameter int OPC_W    = 3,
    parameter int FUNCT_W  = 4,
    parameter int ALUOP_W  = 4,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               mem_ready,
    input  logic               stall,
    output logic               Branch,
    output logic               IoD,
    output logic               IRWrite,
    output logic               Mem2Reg,
    output logic               MemR,
    output logic               MemW,
    output logic               PCSrc,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               Decoding,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         BranchType,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [3:0]         state,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   retired
);

    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_RTYPE    = 4'd2,
        S_RITYPE   = 4'd3,
        S_RTYPEEND = 4'd4,
        S_LW1      = 4'd5,
        S_LW2      = 4'd6,
        S_SW       = 4'd7,
        S_JALR     = 4'd8,
        S_BRANCH   = 4'd9,
        S_BRANCH2  = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    state_t             state_q, state_d;
    logic [WW-1:0]      wait_q, wait_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   ret_q;
    logic               retire;
    logic               timeout;
    logic [ALUOP_W-1:0] alu_map;

    assign timeout = (wait_q == WW'(WAIT_MAX));

    // funct -> ALU operation; load/store functs and reserved codes add
    always_comb begin
        alu_map = '0;
        if (funct <= FUNCT_W'(8))
            alu_map = ALUOP_W'(funct);
        else if (funct == FUNCT_W'(12))
            alu_map = ALUOP_W'(12);
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cause_q <= 2'b00;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            if (retire && (ret_q != '1))
                ret_q <= ret_q + CNT_W'(1);
        end
    end

    // Next state. Stall freezes everything; the wait counter only
    // survives a cycle when a memory state keeps waiting.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cause_d = cause_q;
        retire  = 1'b0;
        if (!stall) begin
            wait_d = '0;
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_TRAP;
                        cause_d = 2'b10;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                S_DECODE: begin
                    if (opcode == OPC_W'(0)) begin
                        state_d = S_RTYPE;
                    end else if (opcode == OPC_W'(1)) begin
                        if (funct == FUNCT_W'(11))
                            state_d = S_JALR;
                        else if (funct >= FUNCT_W'(12))
                            state_d = S_BRANCH;
                        else
                            state_d = S_RITYPE;
                    end else if (opcode == OPC_W'(2)) begin
                        state_d = S_RITYPE;
                    end else if (opcode == OPC_W'(3)) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else if (opcode == OPC_W'(4)) begin
                        state_d = S_JAL;
                    end else begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                end
                S_RTYPE: state_d = S_RTYPEEND;
                S_RITYPE: begin
                    if (funct == FUNCT_W'(9))
                        state_d = S_LW1;
                    else if (funct == FUNCT_W'(10))
                        state_d = S_SW;
                    else
                        state_d = S_RTYPEEND;
                end
                S_LW1: begin
                    if (mem_ready) begin
                        state_d = S_LW2;
                    end else if (timeout) begin
                        state_d = S_TRAP;
                        cause_d = 2'b10;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                S_SW: begin
                    if (mem_ready) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else if (timeout) begin
                        state_d = S_TRAP;
                        cause_d = 2'b10;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                S_BRANCH: state_d = S_BRANCH2;
                S_RTYPEEND, S_LW2, S_JAL, S_JALR, S_BRANCH2: begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                S_TRAP: state_d = S_TRAP;
                default: state_d = S_FETCH;
            endcase
        end
    end

    // Moore outputs, then stall masks every write/access enable
    always_comb begin
        Branch     = 1'b0;
        IoD        = 1'b0;
        IRWrite    = 1'b0;
        Mem2Reg    = 1'b0;
        MemR       = 1'b0;
        MemW       = 1'b0;
        PCSrc      = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        Decoding   = 1'b0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        BranchType = 2'd0;
        ALUOp      = '1;
        case (state_q)
            S_FETCH: begin
                ALUOp   = '0;
                ALUSrcB = 2'd1;
                MemR    = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: Decoding = 1'b1;
            S_RTYPE: begin
                ALUSrcA = 2'd2;
                ALUOp   = alu_map;
            end
            S_RITYPE: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd2;
                ALUOp   = alu_map;
            end
            S_RTYPEEND: RegWrite = 1'b1;
            S_LW1: begin
                IoD  = 1'b1;
                MemR = 1'b1;
            end
            S_LW2: begin
                Mem2Reg  = 1'b1;
                RegWrite = 1'b1;
            end
            S_SW: begin
                IoD  = 1'b1;
                MemW = mem_ready;
            end
            S_JALR: begin
                ALUSrcA  = 2'd3;
                ALUSrcB  = 2'd2;
                ALUOp    = ALUOP_W'(12);
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'd2;
                ALUOp      = '0;
                Branch     = 1'b1;
                BranchType = funct[1:0];
            end
            S_BRANCH2: begin
                ALUSrcA    = 2'd2;
                ALUOp      = ALUOP_W'(1);
                Branch     = 1'b1;
                BranchType = funct[1:0];
                PCSrc      = 1'b1;
                PCWrite    = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = 2'd3;
                ALUSrcB = 2'd2;
                ALUOp   = ALUOP_W'(12);
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        if (stall) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemW     = 1'b0;
            MemR     = 1'b0;
        end
    end

    assign state      = state_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign retired    = ret_q;

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Bench for multicycle_ctrl_v2: directed scenarios plus random stimulus
// compared cycle by cycle against an integer-level reference model.
module tb_multicycle_ctrl_v2;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 15;
    localparam int RET_MAX  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             Reset;
    logic [2:0]       opcode;
    logic [3:0]       funct;
    logic             mem_ready;
    logic             stall;
    logic             Branch, IoD, IRWrite, Mem2Reg, MemR, MemW;
    logic             PCSrc, PCWrite, RegWrite, Decoding;
    logic [1:0]       ALUSrcA, ALUSrcB, BranchType;
    logic [3:0]       ALUOp;
    logic [3:0]       state;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;

    always #5 CLK = ~CLK;

    multicycle_ctrl_v2 #(
        .OPC_W(3), .FUNCT_W(4), .ALUOP_W(4),
        .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .stall(stall),
        .Branch(Branch), .IoD(IoD), .IRWrite(IRWrite),
        .Mem2Reg(Mem2Reg), .MemR(MemR), .MemW(MemW),
        .PCSrc(PCSrc), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .Decoding(Decoding), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .BranchType(BranchType), .ALUOp(ALUOp), .state(state),
        .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    int checks   = 0;
    int failures = 0;

    int m_state = 0;
    int m_wait  = 0;
    int m_cause = 0;
    int m_ret   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] ref_out(int s, int fn, bit rdy, bit stl);
        bit br = 0, iod = 0, irw = 0, m2r = 0, mr = 0;
        bit mw = 0, pcs = 0, pcw = 0, rw = 0, dec = 0;
        int sa = 0, sb = 0, bt = 0, op = 15;
        int mp;
        mp = (fn <= 8) ? fn : ((fn == 12) ? 12 : 0);
        case (s)
            0:  begin op = 0; sb = 1; mr = 1; irw = rdy; pcw = rdy; end
            1:  dec = 1;
            2:  begin sa = 2; sb = 0; op = mp; end
            3:  begin sa = 2; sb = 2; op = mp; end
            4:  rw = 1;
            5:  begin iod = 1; mr = 1; end
            6:  begin m2r = 1; rw = 1; end
            7:  begin iod = 1; mw = rdy; end
            8:  begin sa = 3; sb = 2; op = 12; rw = 1; end
            9:  begin sb = 2; op = 0; br = 1; bt = fn % 4; end
            10: begin sa = 2; op = 1; br = 1; bt = fn % 4; pcs = 1; pcw = 1; end
            11: begin sa = 3; sb = 2; op = 12; pcw = 1; end
            default: ;
        endcase
        if (stl) begin
            irw = 0; pcw = 0; rw = 0; mw = 0; mr = 0;
        end
        return {br, iod, irw, m2r, mr, mw, pcs, pcw, rw, dec,
                2'(sa), 2'(sb), 2'(bt), 4'(op)};
    endfunction

    task automatic model_step(int op, int fn, bit rdy, bit stl, bit rst);
        int nxt;
        int nw;
        bit ret;
        if (!rst) begin
            m_state = 0; m_wait = 0; m_cause = 0; m_ret = 0;
        end else if (!stl) begin
            nxt = m_state;
            nw  = 0;
            ret = 0;
            case (m_state)
                0, 5, 7: begin
                    if (rdy) begin
                        nxt = (m_state == 0) ? 1 : ((m_state == 5) ? 6 : 0);
                        ret = (m_state == 7);
                    end else if (m_wait == WAIT_MAX) begin
                        nxt = 15;
                        m_cause = 2;
                    end else begin
                        nw = m_wait + 1;
                    end
                end
                1: begin
                    if (op == 0) nxt = 2;
                    else if (op == 1) nxt = (fn == 11) ? 8 : ((fn >= 12) ? 9 : 3);
                    else if (op == 2) nxt = 3;
                    else if (op == 3) begin nxt = 0; ret = 1; end
                    else if (op == 4) nxt = 11;
                    else begin nxt = 15; m_cause = 1; end
                end
                2: nxt = 4;
                3: nxt = (fn == 9) ? 5 : ((fn == 10) ? 7 : 4);
                9: nxt = 10;
                4, 6, 8, 10, 11: begin nxt = 0; ret = 1; end
                15: nxt = 15;
                default: nxt = 0;
            endcase
            m_state = nxt;
            m_wait  = nw;
            if (ret && m_ret < RET_MAX) m_ret++;
        end
    endtask

    task automatic cyc(int op, int fn, bit rdy, bit stl, bit rst);
        @(negedge CLK);
        opcode    = 3'(op);
        funct     = 4'(fn);
        mem_ready = rdy;
        stall     = stl;
        Reset     = rst;
        #1;
        check("state", 32'(state), 32'(m_state));
        check("outs", 32'({Branch, IoD, IRWrite, Mem2Reg, MemR, MemW, PCSrc,
                           PCWrite, RegWrite, Decoding, ALUSrcA, ALUSrcB,
                           BranchType, ALUOp}),
              32'(ref_out(m_state, fn, rdy, stl)));
        check("trap", 32'(trap), 32'(m_state == 15));
        check("cause", 32'(trap_cause), 32'(m_cause));
        check("retired", 32'(retired), 32'(m_ret));
        @(posedge CLK);
        model_step(op, fn, rdy, stl, rst);
    endtask

    task automatic do_reset();
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
    endtask

    initial begin
        Reset = 1'b0; opcode = '0; funct = '0;
        mem_ready = 1'b1; stall = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        do_reset();

        // R-type add path
        repeat (4) cyc(0, 1, 1, 0, 1);
        #1;
        check("rtype_state", 32'(state), 0);
        check("rtype_ret", 32'(retired), 1);

        // load with three wait cycles in LW1
        do_reset();
        repeat (3) cyc(1, 9, 1, 0, 1);
        repeat (3) cyc(1, 9, 0, 0, 1);
        repeat (2) cyc(1, 9, 1, 0, 1);
        #1;
        check("lw_ret", 32'(retired), 1);

        // beq through BRANCH/BRANCH2
        do_reset();
        repeat (5) cyc(1, 13, 1, 0, 1);
        #1;
        check("beq_ret", 32'(retired), 1);

        // stall in RTYPEEND
        do_reset();
        repeat (3) cyc(0, 1, 1, 0, 1);
        repeat (4) cyc(0, 1, 1, 1, 1);
        #1;
        check("stall_hold", 32'(state), 4);
        cyc(0, 1, 1, 0, 1);
        #1;
        check("stall_rel", 32'(state), 0);
        check("stall_ret", 32'(retired), 1);

        // illegal opcode trap, cleared only by reset
        do_reset();
        repeat (5) cyc(6, 0, 1, 0, 1);
        #1;
        check("ill_state", 32'(state), 15);
        check("ill_cause", 32'(trap_cause), 1);
        cyc(6, 0, 1, 0, 0);
        #1;
        check("ill_rst", 32'(state), 0);
        check("ill_trap", 32'(trap), 0);

        // memory timeout in FETCH
        do_reset();
        repeat (20) cyc(0, 0, 0, 0, 1);
        #1;
        check("to_state", 32'(state), 15);
        check("to_cause", 32'(trap_cause), 2);

        // NOP run saturates the retired counter
        do_reset();
        repeat (40) cyc(3, 0, 1, 0, 1);
        #1;
        check("sat_ret", 32'(retired), RET_MAX);

        // random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            int op, fn;
            bit rdy, stl, rst;
            op  = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7)
                                               : $urandom_range(0, 4);
            fn  = $urandom_range(0, 15);
            rdy = ($urandom_range(0, 9) < 7);
            stl = ($urandom_range(0, 9) < 2);
            rst = ($urandom_range(0, 49) != 0);
            cyc(op, fn, rdy, stl, rst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_v2.md
Name: multicycle_ctrl_v2

Overview:
- Parametrised next-generation multi-cycle control FSM for the 16-bit processor.
- Decodes opcode/funct fields and sequences the datapath through fetch, decode, execute, memory and writeback states, like the current controller.
- Adds a memory-ready handshake with timeout, a stall input and an illegal-opcode trap state.
- Adds a retired-instruction counter.
- All ALUOp encodings are defined; there are no x outputs.

Parameters:
- OPC_W, 3, opcode field width (instr bits [OPC_W-1:0] of the control input).
- FUNCT_W, 4, funct field width.
- ALUOP_W, 4, ALUOp output width; must be at least 4.
- WAIT_MAX, 15, maximum mem_ready wait cycles before timeout trap.
- CNT_W, 16, retired-instruction counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  reset.
- opcode  in  OPC_W  instruction opcode.
- funct  in  FUNCT_W  instruction funct field.
- mem_ready  in  1  memory completes the current access this cycle.
- stall  in  1  freeze FSM and suppress all write enables.
- Branch, IoD, IRWrite, Mem2Reg, MemR, MemW, PCSrc, PCWrite, RegWrite, Decoding  out  1 each  datapath controls.
- ALUSrcA, ALUSrcB, BranchType  out  2 each.
- ALUOp  out  ALUOP_W.
- state  out  4  current state code.
- trap  out  1  sticky; FSM in TRAP.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- retired  out  CNT_W  saturating count of completed instructions.

Behaviour:
- Reset interface (already decided): one clock, CLK; reset is synchronous and active-low, port Reset. Reset=0 at a CLK edge returns the block to reset state.
- Reset values:
  - state=FETCH, wait counter=0, trap=0, trap_cause=00, retired=0.
  - Combinational outputs then show FETCH values.
- State codes: FETCH=0, DECODE=1, RTYPE=2, RITYPE=3, RTYPEEND=4, LW1=5, LW2=6, SW=7, JALR=8, BRANCH=9, BRANCH2=10, JAL=11, TRAP=15.
- Outputs are Moore, decoded from state. Default for every signal is 0, except ALUOp = all-ones.
- FETCH: ALUOp=0, ALUSrcB=1, MemR=1, IRWrite=mem_ready, PCWrite=mem_ready.
- DECODE: Decoding=1.
- RTYPE: ALUSrcA=2, ALUSrcB=0, ALUOp=map(funct).
- RITYPE: ALUSrcA=2, ALUSrcB=2, ALUOp=map(funct).
- RTYPEEND: RegWrite=1.
- LW1: IoD=1, MemR=1.
- LW2: Mem2Reg=1, RegWrite=1.
- SW: IoD=1, MemW=mem_ready.
- JALR: ALUSrcA=3, ALUSrcB=2, ALUOp=12, RegWrite=1.
- BRANCH: ALUSrcB=2, ALUOp=0, Branch=1, BranchType=funct[1:0].
- BRANCH2: ALUSrcA=2, ALUOp=1, Branch=1, BranchType=funct[1:0], PCSrc=1, PCWrite=1.
- JAL: ALUSrcA=3, ALUSrcB=2, ALUOp=12, PCWrite=1.
- TRAP: all outputs at default.
- map(funct):
  - 0..8 pass through.
  - 9 and 10 give 0.
  - 12 gives 12.
  - All others give 0.
  - Result is zero-extended to ALUOP_W.
- Transitions, evaluated only when stall=0:
  - FETCH to DECODE.
  - DECODE by opcode:
    - 0 to RTYPE.
    - 1 with funct 11 to JALR; funct 12..15 to BRANCH; else RITYPE.
    - 2 to RITYPE.
    - 3 (NOP) to FETCH.
    - 4 to JAL.
    - 5..max to TRAP with cause 01.
  - RTYPE to RTYPEEND.
  - RITYPE: funct 9 to LW1, funct 10 to SW, else RTYPEEND.
  - LW1 to LW2.
  - BRANCH to BRANCH2.
  - RTYPEEND, LW2, SW, JAL, JALR, BRANCH2 to FETCH.
  - TRAP holds until reset.
- Memory wait: FETCH, LW1 and SW advance only when mem_ready=1.
  - Wait counter increments each cycle spent waiting.
  - Wait counter clears on advance and on entering any state.
  - If the counter reaches WAIT_MAX while mem_ready=0, go to TRAP with cause 10.
- Stall=1:
  - State and wait counter hold; the counter does not increment.
  - IRWrite, PCWrite, RegWrite, MemW and MemR are forced to 0. Other outputs are unchanged.
  - Stall takes priority over mem_ready and timeout.
- retired increments by 1 on each transition into FETCH from RTYPEEND, LW2, SW, JAL, JALR, BRANCH2 or DECODE (NOP). It saturates at all-ones.
- Illegal or unused state codes go to FETCH on the next edge and do not set trap.
- Reset mid-operation or in TRAP: Reset=0 wins over everything; all state returns to reset values at that edge.

Test Plan:
- Reset=0 for 2 cycles, then 1; R-type opcode=0, funct=1, mem_ready=1 -> states 0,1,2,4,0; ALUOp=1 in RTYPE; RegWrite=1 only in state 4; retired=1.
- lw: opcode=1, funct=9; mem_ready low for 3 cycles in LW1 -> state 5 held 3 extra cycles, MemR=1, IoD=1 throughout; then LW2 with Mem2Reg=1; retired=1.
- Beq: opcode=1, funct=13 -> BRANCH shows BranchType=01, ALUOp=0; BRANCH2 shows PCSrc=1, PCWrite=1, ALUOp=1.
- stall=1 for 4 cycles while in RTYPEEND -> state stays 4, RegWrite=0; on release, exactly one RegWrite pulse, then FETCH.
- opcode=6 at DECODE -> state 15, trap=1, trap_cause=01; the next Reset=0 edge -> state 0, trap=0.
- mem_ready held 0 in FETCH with WAIT_MAX=15 -> TRAP after 15 wait cycles, trap_cause=10, PCWrite never asserted. Separately: retired preloaded at all-ones by a long NOP run with CNT_W=4 -> saturates at 15.
